// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, two combinational read ports,
// one write port and an issue port. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_sb #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [AW-1:0]              addrA,
    input  logic [AW-1:0]              addrB,
    output logic [WIDTH-1:0]           dataA,
    output logic [WIDTH-1:0]           dataB,
    output logic                       busyA,
    output logic                       busyB,
    input  logic                       we,
    input  logic [AW-1:0]              addrR,
    input  logic [WIDTH-1:0]           dataR,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_addr,
    output logic                       issue_ready,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int PW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_next;
    logic [PW-1:0]    pending_q;
    logic [PW-1:0]    pending_next;
    logic             issue_set;
    logic             write_eff;
    logic             write_clr;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign issue_ready = is_zero(issue_addr) || !busy[issue_addr];
    assign issue_set   = issue_valid && issue_ready && !is_zero(issue_addr);
    assign write_eff   = we && !is_zero(addrR);
    // A same-register issue wins over the write's clear, so that case never counts down.
    assign write_clr   = write_eff && busy[addrR] && !(issue_set && (issue_addr == addrR));

    always_comb begin
        busy_next = busy;
        if (write_eff) begin
            busy_next[addrR] = 1'b0;
        end
        if (issue_set) begin
            busy_next[issue_addr] = 1'b1;
        end
    end

    always_comb begin
        pending_next = pending_q;
        case ({issue_set, write_clr})
            2'b10:   pending_next = pending_q + PW'(1);
            2'b01:   pending_next = pending_q - PW'(1);
            default: pending_next = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy      <= '0;
            pending_q <= '0;
        end else begin
            if (write_eff) begin
                regs[addrR] <= dataR;
            end
            busy      <= busy_next;
            pending_q <= pending_next;
        end
    end

    assign pending = pending_q;

    always_comb begin
        dataA = regs[addrA];
        busyA = busy[addrA];
        if (is_zero(addrA)) begin
            dataA = '0;
            busyA = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (write_eff && (addrR == addrA)) begin
            dataA = dataR;
            busyA = 1'b0;
        end
`endif
    end

    always_comb begin
        dataB = regs[addrB];
        busyB = busy[addrB];
        if (is_zero(addrB)) begin
            dataB = '0;
            busyB = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (write_eff && (addrR == addrB)) begin
            dataB = dataR;
            busyB = 1'b0;
        end
`endif
    end

endmodule
